// File: rtl/data_concat_pkg.sv
// rtl/data_concat_pkg.sv - shared constants, types and sizing helper for the sample-to-byte packer
package data_concat_pkg;

    localparam int SAMPLE_W  = 18;
    localparam int N_SAMPLES = 4;
    localparam int BYTE_W    = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [BYTE_W-1:0]   byte_t;

    function automatic int calc_n_bytes(input int n_samples, input int sample_w, input int byte_w);
        return (n_samples * sample_w) / byte_w;
    endfunction

endpackage

// File: rtl/data_concat_concat_map.sv
// rtl/data_concat_concat_map.sv - combinational flatten of samples and byte-lane slicing
module concat_map
    import data_concat_pkg::*;
#(
    parameter int N_SAMPLES = data_concat_pkg::N_SAMPLES,
    parameter int SAMPLE_W  = data_concat_pkg::SAMPLE_W,
    parameter int BYTE_W    = data_concat_pkg::BYTE_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [N_SAMPLES-1:0][SAMPLE_W-1:0]                              x_i,
    output logic [calc_n_bytes(N_SAMPLES, SAMPLE_W, BYTE_W)-1:0][BYTE_W-1:0] y_o
);

    localparam int P_W     = N_SAMPLES * SAMPLE_W;
    localparam int N_BYTES = calc_n_bytes(N_SAMPLES, SAMPLE_W, BYTE_W);

    if ((P_W % BYTE_W) != 0) begin : g_bad_width
        $fatal(1, "data_concat: N_SAMPLES*SAMPLE_W must be a multiple of BYTE_W");
    end

    // Packed 2-D layout already places x[0] in the low bits, giving the packed word directly.
    logic [P_W-1:0] p;
    assign p = x_i;

    for (genvar k = 0; k < N_BYTES; k++) begin : g_lane
        localparam int SRC = MSB_FIRST ? (N_BYTES - 1 - k) : k;
        assign y_o[k] = p[BYTE_W*SRC +: BYTE_W];
    end

endmodule

// File: rtl/data_concat.sv
// rtl/data_concat.sv - registered sample-to-byte packer with one-cycle valid pipeline
module data_concat
    import data_concat_pkg::*;
#(
    parameter int N_SAMPLES = data_concat_pkg::N_SAMPLES,
    parameter int SAMPLE_W  = data_concat_pkg::SAMPLE_W,
    parameter int BYTE_W    = data_concat_pkg::BYTE_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                                                             clk,
    input  logic                                                             rst,
    input  logic [N_SAMPLES-1:0][SAMPLE_W-1:0]                               x,
    input  logic                                                             in_valid,
    output logic [calc_n_bytes(N_SAMPLES, SAMPLE_W, BYTE_W)-1:0][BYTE_W-1:0] y,
    output logic                                                             out_valid
);

    localparam int N_BYTES = calc_n_bytes(N_SAMPLES, SAMPLE_W, BYTE_W);

    logic [N_BYTES-1:0][BYTE_W-1:0] mapped;
    logic [N_BYTES-1:0][BYTE_W-1:0] y_d, y_q;
    logic                           valid_d, valid_q;

    concat_map #(
        .N_SAMPLES (N_SAMPLES),
        .SAMPLE_W  (SAMPLE_W),
        .BYTE_W    (BYTE_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_map (
        .x_i (x),
        .y_o (mapped)
    );

    // Output word only advances on valid input; otherwise the last packed word is held.
    always_comb begin
        y_d     = y_q;
        valid_d = in_valid;
        if (in_valid) begin
            y_d = mapped;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_data_concat.sv
// tb/tb_data_concat.sv - randomized self-checking bench for data_concat (LSB- and MSB-first lanes)
module tb_data_concat;
    import data_concat_pkg::*;

    localparam int NS = 4;
    localparam int SW = 18;
    localparam int BW = 8;
    localparam int NB = 9;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NS-1:0][SW-1:0]   x = '0;
    logic                    in_valid = 1'b0;
    logic [NB-1:0][BW-1:0]   y_lsb, y_msb;
    logic                    ov_lsb, ov_msb;

    int total = 0;
    int bad   = 0;

    logic [NB*BW-1:0] exp_lsb, exp_msb;
    logic             exp_v;

    always #5 clk = ~clk;

    data_concat #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .y(y_lsb), .out_valid(ov_lsb)
    );

    data_concat #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .y(y_msb), .out_valid(ov_msb)
    );

    task automatic check(input string tag, input logic [NB*BW-1:0] got, input logic [NB*BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Literal written as y[0], y[1], ... y[8] left to right; returns the packed y vector.
    function automatic logic [NB*BW-1:0] listed(input logic [NB*BW-1:0] l);
        logic [NB*BW-1:0] r;
        for (int k = 0; k < NB; k++) r[BW*k +: BW] = l[BW*(NB-1-k) +: BW];
        return r;
    endfunction

    // Reference: treat the samples as one big number, then peel off bytes arithmetically.
    function automatic logic [NB*BW-1:0] ref_pack(input logic [NS-1:0][SW-1:0] xs, input bit msb);
        logic [NS*SW-1:0] p;
        logic [NB*BW-1:0] r;
        sample_t          s;
        p = '0;
        for (int i = 0; i < NS; i++) begin
            s = xs[i];
            p = p + ((NS*SW)'(s) << (i * SW));
        end
        for (int k = 0; k < NB; k++) begin
            int lane;
            lane = msb ? (NB - 1 - k) : k;
            r[BW*lane +: BW] = BW'((p >> (BW * k)) & 'hFF);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [NS*SW-1:0] PAT_A = {18'h00000, 18'h0FFFF, 18'h00000, 18'h0FFFF};
    localparam logic [NS*SW-1:0] PAT_B = {18'h0CC00, 18'h00033, 18'h0CC00, 18'h00033};

    logic [NB*BW-1:0] a_lsb, a_msb, b_lsb;

    initial begin
        a_lsb = listed(72'hFFFF0000F0FF0F0000);
        a_msb = listed(72'h00000FFFF00000FFFF);
        b_lsb = listed(72'h3300003033030000_33);

        rst = 1'b0; in_valid = 1'b1; x = PAT_A;
        tick(); tick();
        check("reset_y",  y_lsb, '0);
        check("reset_ov", 72'(ov_lsb), 72'(1'b0));

        rst = 1'b1; in_valid = 1'b1; x = PAT_A;
        tick();
        check("a_ov",    72'(ov_lsb), 72'(1'b1));
        check("a_lsb",   y_lsb, a_lsb);
        check("a_msb",   y_msb, a_msb);
        check("a_model", y_lsb, ref_pack(PAT_A, 1'b0));

        x = PAT_B;
        tick();
        check("b_ov",  72'(ov_lsb), 72'(1'b1));
        check("b_lsb", y_lsb, b_lsb);
        check("b_msb", y_msb, ref_pack(PAT_B, 1'b1));

        in_valid = 1'b0; x = '1;
        tick();
        check("hold_ov", 72'(ov_lsb), 72'(1'b0));
        check("hold_y",  y_lsb, b_lsb);

        in_valid = 1'b1; x = PAT_A; rst = 1'b0;
        tick();
        check("mid_rst_y",  y_lsb, '0);
        check("mid_rst_ov", 72'(ov_lsb), 72'(1'b0));
        check("mid_rst_ym", y_msb, '0);

        rst = 1'b1; in_valid = 1'b0;
        tick();
        check("post_rst_idle_ov", 72'(ov_lsb), 72'(1'b0));
        check("post_rst_idle_y",  y_lsb, '0);
        in_valid = 1'b1; x = PAT_B;
        tick();
        check("post_rst_first_ov", 72'(ov_lsb), 72'(1'b1));
        check("post_rst_first_y",  y_lsb, b_lsb);

        exp_lsb = b_lsb;
        exp_msb = ref_pack(PAT_B, 1'b1);
        exp_v   = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < NS; i++) x[i] = SW'($urandom);
            in_valid = 1'(($urandom % 4) != 0);
            rst      = 1'(($urandom % 50) != 0);
            if (!rst) begin
                exp_lsb = '0; exp_msb = '0; exp_v = 1'b0;
            end else begin
                exp_v = in_valid;
                if (in_valid) begin
                    exp_lsb = ref_pack(x, 1'b0);
                    exp_msb = ref_pack(x, 1'b1);
                end
            end
            tick();
            check("rnd_ov_lsb", 72'(ov_lsb), 72'(exp_v));
            check("rnd_ov_msb", 72'(ov_msb), 72'(exp_v));
            check("rnd_y_lsb",  y_lsb, exp_lsb);
            check("rnd_y_msb",  y_msb, exp_msb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
